// File: rtl/reaction_controller.sv
// reaction_controller: top-level reaction-timer game FSM running on the 1 kHz tick clock (1 cycle = 1 ms).
//
// The player presses to arm; after a pseudo-random delay the stimulus LED lights and the
// external stopwatch is started. The next press captures the reaction time from the
// stopwatch count. Pressing early is a false start; not pressing in time is a timeout.
//
// Ports:
//   clk_in        1 kHz clock
//   rst           asynchronous, active-high reset
//   btn           raw player button, asynchronous to clk_in
//   elapsed_time  stopwatch count 0..9999 ms, wraps 9999 -> 0
//   start_watch   registered run enable for the stopwatch, high only while waiting for the response
//   stim_led      registered stimulus LED, high only while waiting for the response
//   result_ms     last measured reaction time in ms, held until the next capture or reset
//   result_valid  high while a measured result is being shown
//   false_start   high after a press before the stimulus
//   timeout       high after the response window expired without a press
module reaction_controller #(
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 2000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        btn,
    input  logic [13:0] elapsed_time,
    output logic        start_watch,
    output logic        stim_led,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout
);
    // Wide enough for the largest delay MIN_DELAY_MS + 2^RAND_BITS - 1.
    localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RESP,
        CAPTURE,
        SHOW,
        FALSE_START,
        TIMEOUT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q;
    logic          lfsr_fb;
    logic          s1_q, s2_q, s3_q;
    logic          press;
    logic [DW-1:0] delay_cnt_q, delay_cnt_d;
    logic [13:0]   resp_cnt_q, resp_cnt_d;
    logic [13:0]   base_q, base_d;
    logic [13:0]   result_q, result_d;
    logic [14:0]   el15, bs15;
    logic [13:0]   lap;
    logic          start_watch_q, stim_led_q, result_valid_q, false_start_q, timeout_q;

    // Two synchronizer flops plus a history flop; press is one cycle per rising edge.
    assign press = s2_q & ~s3_q;

    // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Stopwatch wraps at 10000, so a count below the base means it wrapped once.
    assign el15 = {1'b0, elapsed_time};
    assign bs15 = {1'b0, base_q};
    assign lap  = 14'((el15 >= bs15) ? el15 - bs15 : el15 + 15'd10000 - bs15);

    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        base_d      = base_q;
        result_d    = result_q;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    delay_cnt_d = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
                    state_d     = ARM;
                end
            end
            ARM: begin
                // A press wins over expiry in the same cycle.
                if (press) begin
                    state_d = FALSE_START;
                end else if (delay_cnt_q == '0) begin
                    // Base is sampled on the edge the stopwatch starts, so the count
                    // advances exactly once per WAIT_RESP cycle.
                    base_d     = elapsed_time;
                    resp_cnt_d = '0;
                    state_d    = WAIT_RESP;
                end else begin
                    delay_cnt_d = delay_cnt_q - DW'(1);
                end
            end
            WAIT_RESP: begin
                resp_cnt_d = resp_cnt_q + 14'd1;
                if (press)
                    state_d = CAPTURE;
                else if (resp_cnt_q == 14'(TIMEOUT_MS - 1))
                    state_d = TIMEOUT;
            end
            CAPTURE: begin
                // Stopwatch is stopped here and already shows its final increment.
                result_d = lap;
                state_d  = SHOW;
            end
            SHOW, FALSE_START, TIMEOUT: begin
                if (press)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            lfsr_q         <= 16'hACE1;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            delay_cnt_q    <= '0;
            resp_cnt_q     <= '0;
            base_q         <= '0;
            result_q       <= '0;
            start_watch_q  <= 1'b0;
            stim_led_q     <= 1'b0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= {lfsr_q[14:0], lfsr_fb};
            s1_q           <= btn;
            s2_q           <= s1_q;
            s3_q           <= s2_q;
            delay_cnt_q    <= delay_cnt_d;
            resp_cnt_q     <= resp_cnt_d;
            base_q         <= base_d;
            result_q       <= result_d;
            // Flags are registered from the next state so they change on the state edge.
            start_watch_q  <= (state_d == WAIT_RESP);
            stim_led_q     <= (state_d == WAIT_RESP);
            result_valid_q <= (state_d == SHOW);
            false_start_q  <= (state_d == FALSE_START);
            timeout_q      <= (state_d == TIMEOUT);
        end
    end

    assign start_watch  = start_watch_q;
    assign stim_led     = stim_led_q;
    assign result_ms    = result_q;
    assign result_valid = result_valid_q;
    assign false_start  = false_start_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_controller.sv
// tb_reaction_controller: directed bench for reaction_controller with a stopwatch model alongside.
module tb_reaction_controller;
    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        btn = 1'b0;
    logic [13:0] elapsed_time;
    logic        start_watch, stim_led, result_valid, false_start, timeout;
    logic [13:0] result_ms;

    logic        sw_load = 1'b0;
    logic [13:0] sw_load_val = '0;
    logic [15:0] lfsr_m;
    int          stim_hits = 0;

    int n_checks = 0;
    int n_fail = 0;
    int bad_out, bad_lfsr, cyc, d, sw0, hits0, n;

    always #5 clk_in = ~clk_in;

    reaction_controller #(
        .MIN_DELAY_MS(10),
        .RAND_BITS   (4),
        .TIMEOUT_MS  (300)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .btn         (btn),
        .elapsed_time(elapsed_time),
        .start_watch (start_watch),
        .stim_led    (stim_led),
        .result_ms   (result_ms),
        .result_valid(result_valid),
        .false_start (false_start),
        .timeout     (timeout)
    );

    // Stopwatch: counts while start_watch is high, wraps 9999 -> 0, preloadable.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            elapsed_time <= '0;
        else if (sw_load)
            elapsed_time <= sw_load_val;
        else if (start_watch)
            elapsed_time <= (elapsed_time == 14'd9999) ? 14'd0 : elapsed_time + 14'd1;
    end

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting left, seed ACE1.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            lfsr_m <= 16'hACE1;
        else
            lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    // Counts cycles in which either stimulus output was seen high.
    always_ff @(posedge clk_in)
        stim_hits <= stim_hits + int'(stim_led | start_watch);

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise btn at a negedge, hold it, release; the press is sampled on the 3rd posedge.
    task automatic press();
        btn = 1'b1;
        repeat (4) @(negedge clk_in);
        btn = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    // Returns at the first negedge with stim_led high, or fails after a bounded wait.
    task automatic wait_stim();
        int k = 0;
        while (!stim_led && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        check("stim_seen", int'(stim_led), 1);
    endtask

    initial begin
        // ---------------- reset, idle, LFSR sequence ----------------
        #2 rst = 1'b1;
        repeat (2) @(negedge clk_in);
        check("rst_lfsr", int'(dut.lfsr_q), 16'hACE1);
        check("rst_outs", int'({start_watch, stim_led, result_valid, false_start, timeout}), 0);
        check("rst_result", int'(result_ms), 0);
        rst = 1'b0;
        @(negedge clk_in);
        check("lfsr_step1", int'(dut.lfsr_q), 16'h59C3);
        @(negedge clk_in);
        check("lfsr_step2", int'(dut.lfsr_q), 16'hB387);
        bad_out  = 0;
        bad_lfsr = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_in);
            if ({start_watch, stim_led, result_valid, false_start, timeout} != 5'b0 ||
                result_ms != 14'd0 || int'(dut.state_q) != 0)
                bad_out++;
            if (dut.lfsr_q !== lfsr_m)
                bad_lfsr++;
        end
        check("idle_outs_bad", bad_out, 0);
        check("lfsr_seq_bad", bad_lfsr, 0);

        // ---------------- normal reaction ----------------
        btn = 1'b1;
        repeat (2) @(negedge clk_in);
        d = 10 + int'(lfsr_m[3:0]);    // LFSR value sampled on the press edge
        cyc = 2;
        while (!stim_led && cyc < 60) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 4) btn = 1'b0;
        end
        // 3 edges to sample the press, then d+1 cycles in ARM.
        check("stim_delay", cyc, d + 4);
        check("stim_watch_on", int'(start_watch), 1);
        sw0 = int'(elapsed_time);
        // btn rises so that it is sampled on the 250th edge after stim_led rose.
        repeat (249) @(negedge clk_in);
        btn = 1'b1;
        repeat (2) @(negedge clk_in);
        check("pre_capture_led", int'(stim_led), 1);
        @(negedge clk_in);
        check("capture_watch_off", int'(start_watch), 0);
        check("capture_sw_adv", int'(elapsed_time) - sw0, 252);
        @(negedge clk_in);
        check("show_valid", int'(result_valid), 1);
        check("show_result", int'(result_ms), 252);
        check("show_watch_off", int'(start_watch), 0);
        btn = 1'b0;
        repeat (3) @(negedge clk_in);
        press();
        check("back_idle", int'(dut.state_q), 0);
        check("idle_valid_low", int'(result_valid), 0);
        check("idle_result_held", int'(result_ms), 252);

        // ---------------- false start ----------------
        hits0 = stim_hits;
        press();
        check("fs_in_arm", int'(dut.state_q), 1);
        press();
        check("fs_flag", int'(false_start), 1);
        check("fs_result_held", int'(result_ms), 252);
        check("fs_no_stim", stim_hits - hits0, 0);
        check("fs_only_flag", int'({result_valid, timeout}), 0);
        press();
        check("fs_cleared", int'(false_start), 0);

        // ---------------- timeout ----------------
        press();
        wait_stim();
        sw0 = int'(elapsed_time);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (stim_led && n < 400);
        check("to_stim_cycles", n, 300);
        check("to_flag", int'(timeout), 1);
        check("to_watch_off", int'(start_watch), 0);
        check("to_sw_adv", (int'(elapsed_time) - sw0 + 10000) % 10000, 300);
        check("to_result_held", int'(result_ms), 252);
        press();
        check("to_cleared", int'(timeout), 0);

        // ---------------- stopwatch wrap ----------------
        press();
        sw_load_val = 14'd9990;
        sw_load = 1'b1;
        @(negedge clk_in);
        sw_load = 1'b0;
        wait_stim();
        check("wrap_base", int'(elapsed_time), 9990);
        // btn sampled on the 28th edge; press registers 2 edges later.
        repeat (27) @(negedge clk_in);
        btn = 1'b1;
        repeat (3) @(negedge clk_in);
        check("wrap_sw_value", int'(elapsed_time), 20);
        @(negedge clk_in);
        check("wrap_result", int'(result_ms), 30);
        check("wrap_valid", int'(result_valid), 1);
        btn = 1'b0;
        repeat (3) @(negedge clk_in);
        press();

        // ---------------- press coinciding with delay expiry ----------------
        hits0 = stim_hits;
        btn = 1'b1;
        repeat (2) @(negedge clk_in);
        d = 10 + int'(lfsr_m[3:0]);
        @(negedge clk_in);               // just after the edge that loads the delay
        btn = 1'b0;
        // Second press is sampled on the edge where the delay counter reads 0.
        repeat (d - 2) @(negedge clk_in);
        btn = 1'b1;
        repeat (3) @(negedge clk_in);
        check("tie_false_start", int'(false_start), 1);
        check("tie_state", int'(dut.state_q), 5);
        check("tie_no_stim", stim_hits - hits0, 0);
        btn = 1'b0;
        repeat (3) @(negedge clk_in);
        press();

        // ---------------- async reset mid WAIT_RESP ----------------
        press();
        wait_stim();
        repeat (5) @(negedge clk_in);
        check("ar_led_before", int'(stim_led), 1);
        #1 rst = 1'b1;
        #1;
        check("ar_led_drop", int'(stim_led), 0);
        check("ar_watch_drop", int'(start_watch), 0);
        check("ar_state_idle", int'(dut.state_q), 0);
        check("ar_result_clr", int'(result_ms), 0);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        check("ar_stays_idle", int'(dut.state_q), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
